// File: rtl/bank_word_match_seq.sv
// Banked word compare: one-hot bank select, polarity-adjusted reference,
// registered match with hold and saturating miss count. Option: MATCH_STICKY_EN.
module bank_word_match_seq #(
  parameter int WIDTH = 12,
  parameter int NBANK = 3,
  parameter int CNT_W = 8,
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             wr_en,
  input  logic [BW-1:0]    wr_bank,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cmp_req,
  input  logic [NBANK-1:0] sel,
  input  logic [WIDTH-1:0] ref_word,
  input  logic [WIDTH-1:0] ref_pol,
  input  logic             upd_en,
  input  logic             kill,
`ifdef MATCH_STICKY_EN
  input  logic             sticky_clr,
  output logic             miss_sticky,
`endif
  output logic             match,
  output logic             match_vld,
  output logic             sel_err,
  output logic [CNT_W-1:0] miss_cnt
);

  logic [WIDTH-1:0] bank [NBANK];
  logic [WIDTH-1:0] sel_word;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_word;
  logic [WIDTH-1:0] s1_exp;
  logic             s1_err;
  logic             s1_acc;
  logic             eq;
  logic             miss;

  // Out-of-range indices match no bank, so they are dropped.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NBANK; i++)
        bank[i] <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++)
        if (wr_en && wr_bank == BW'(i))
          bank[i] <= wr_data;
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NBANK; i++)
      if (sel[i])
        sel_word = sel_word | bank[i];
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      s1_vld  <= 1'b0;
      s1_word <= '0;
      s1_exp  <= '0;
      s1_err  <= 1'b0;
      s1_acc  <= 1'b0;
    end else begin
      s1_vld <= cmp_req;
      if (cmp_req) begin
        s1_word <= sel_word;
        s1_exp  <= ref_word ^ ref_pol;
        s1_err  <= !$onehot(sel);
        s1_acc  <= upd_en & ~kill;
      end
    end
  end

  assign eq   = &(~(s1_word ^ s1_exp));
  assign miss = s1_vld & s1_acc & ~eq;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      match     <= 1'b0;
      match_vld <= 1'b0;
      sel_err   <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      match_vld <= 1'b0;
      sel_err   <= 1'b0;
      if (s1_vld && s1_acc) begin
        match     <= eq;
        match_vld <= 1'b1;
        sel_err   <= s1_err;
      end
      if (miss && miss_cnt != {CNT_W{1'b1}})
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

`ifdef MATCH_STICKY_EN
  // Set has priority over clear.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)
      miss_sticky <= 1'b0;
    else if (miss)
      miss_sticky <= 1'b1;
    else if (sticky_clr)
      miss_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_bank_word_match_seq.sv
// Directed bench for bank_word_match_seq, default and CNT_W=2 instances.
// Covers MATCH_STICKY_EN when that macro is defined.
module tb_bank_word_match_seq;

  logic        CK = 1'b0;
  logic        RSTN = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [11:0] wr_data = '0;
  logic        cmp_req = 1'b0;
  logic [2:0]  sel = '0;
  logic [11:0] ref_word = '0;
  logic [11:0] ref_pol = '0;
  logic        upd_en = 1'b0;
  logic        kill = 1'b0;
  logic        match, match_vld, sel_err;
  logic [7:0]  miss_cnt;
  logic        match2, match_vld2, sel_err2;
  logic [1:0]  miss_cnt2;
`ifdef MATCH_STICKY_EN
  logic        sticky_clr = 1'b0;
  logic        miss_sticky, miss_sticky2;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 CK = ~CK;

  bank_word_match_seq dut (
    .CK(CK), .RSTN(RSTN),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_data(wr_data),
    .cmp_req(cmp_req), .sel(sel),
    .ref_word(ref_word), .ref_pol(ref_pol),
    .upd_en(upd_en), .kill(kill),
`ifdef MATCH_STICKY_EN
    .sticky_clr(sticky_clr), .miss_sticky(miss_sticky),
`endif
    .match(match), .match_vld(match_vld),
    .sel_err(sel_err), .miss_cnt(miss_cnt)
  );

  bank_word_match_seq #(.CNT_W(2)) dut2 (
    .CK(CK), .RSTN(RSTN),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_data(wr_data),
    .cmp_req(cmp_req), .sel(sel),
    .ref_word(ref_word), .ref_pol(ref_pol),
    .upd_en(upd_en), .kill(kill),
`ifdef MATCH_STICKY_EN
    .sticky_clr(sticky_clr), .miss_sticky(miss_sticky2),
`endif
    .match(match2), .match_vld(match_vld2),
    .sel_err(sel_err2), .miss_cnt(miss_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic wr(input logic [1:0] b, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Issue one request and wait until its result is visible.
  task automatic cmp(input logic [2:0] s, input logic [11:0] r,
                     input logic [11:0] p, input logic u, input logic k);
    cmp_req = 1'b1; sel = s; ref_word = r; ref_pol = p;
    upd_en = u; kill = k;
    step();
    cmp_req = 1'b0; wr_en = 1'b0;
    step();
  endtask

  task automatic chk_out(input string tag, input logic m, input logic v,
                         input logic e);
    int c2;
    c2 = (exp_cnt > 3) ? 3 : exp_cnt;
    check({tag, ".match"}, 32'(match), 32'(m));
    check({tag, ".vld"}, 32'(match_vld), 32'(v));
    check({tag, ".err"}, 32'(sel_err), 32'(e));
    check({tag, ".cnt"}, 32'(miss_cnt), 32'(exp_cnt));
    check({tag, ".cnt2"}, 32'(miss_cnt2), 32'(c2));
  endtask

  initial begin
    repeat (2) step();
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
    step();

    wr(2'd0, 12'hA5C);
    wr(2'd1, 12'h3F0);
    wr(2'd2, 12'hFFF);
    wr(2'd3, 12'h000);

    cmp(3'b010, 12'h3F0, 12'h000, 1'b1, 1'b0);
    chk_out("hit", 1'b1, 1'b1, 1'b0);
    step();
    check("vld_pulse", 32'(match_vld), 32'd0);

    cmp(3'b010, 12'h3F1, 12'h000, 1'b1, 1'b0);
    exp_cnt = 1;
    chk_out("miss", 1'b0, 1'b1, 1'b0);

    cmp(3'b010, 12'h3F1, 12'h001, 1'b1, 1'b0);
    chk_out("pol", 1'b1, 1'b1, 1'b0);

    cmp(3'b010, 12'h3F1, 12'h000, 1'b1, 1'b1);
    chk_out("kill", 1'b1, 1'b0, 1'b0);
    cmp(3'b010, 12'h3F1, 12'h000, 1'b0, 1'b0);
    chk_out("noupd", 1'b1, 1'b0, 1'b0);

    cmp(3'b001, 12'hA5C, 12'h000, 1'b1, 1'b0);
    chk_out("bank3_ign", 1'b1, 1'b1, 1'b0);

    wr_en = 1'b1; wr_bank = 2'd2; wr_data = 12'h000;
    cmp(3'b100, 12'hFFF, 12'h000, 1'b1, 1'b0);
    chk_out("hazard_old", 1'b1, 1'b1, 1'b0);
    cmp(3'b100, 12'hFFF, 12'h000, 1'b1, 1'b0);
    exp_cnt = 2;
    chk_out("hazard_new", 1'b0, 1'b1, 1'b0);

    cmp(3'b011, 12'hBFC, 12'h000, 1'b1, 1'b0);
    chk_out("multihot", 1'b1, 1'b1, 1'b1);
    step();
    check("err_pulse", 32'(sel_err), 32'd0);

    cmp(3'b000, 12'h000, 12'h000, 1'b1, 1'b0);
    chk_out("sel0", 1'b1, 1'b1, 1'b1);

    // Back-to-back: hit then miss, one result per cycle.
    cmp_req = 1'b1; sel = 3'b001; ref_word = 12'hA5C; ref_pol = '0;
    upd_en = 1'b1; kill = 1'b0;
    step();
    ref_word = 12'h000;
    step();
    cmp_req = 1'b0;
    chk_out("b2b_a", 1'b1, 1'b1, 1'b0);
    step();
    exp_cnt = 3;
    chk_out("b2b_b", 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      cmp(3'b100, 12'h123, 12'h000, 1'b1, 1'b0);
      exp_cnt++;
    end
    chk_out("sat", 1'b0, 1'b1, 1'b0);

`ifdef MATCH_STICKY_EN
    check("sticky_set", 32'(miss_sticky), 32'd1);
    sticky_clr = 1'b1;
    cmp(3'b100, 12'h123, 12'h000, 1'b1, 1'b0);
    exp_cnt++;
    check("sticky_win", 32'(miss_sticky), 32'd1);
    step();
    sticky_clr = 1'b0;
    check("sticky_clr", 32'(miss_sticky), 32'd0);
`endif

    cmp(3'b001, 12'hA5C, 12'h000, 1'b1, 1'b0);
    chk_out("pre_rst", 1'b1, 1'b1, 1'b0);

    // Reset with a request sitting in S1.
    cmp_req = 1'b1; sel = 3'b001; ref_word = 12'hA5C;
    step();
    cmp_req = 1'b0;
    RSTN = 1'b0;
    #1;
    exp_cnt = 0;
    chk_out("mid_rst", 1'b0, 1'b0, 1'b0);
    step();
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("post_rst", 1'b0, 1'b0, 1'b0);
    end
    cmp(3'b001, 12'h000, 12'h000, 1'b1, 1'b0);
    chk_out("bank_rst", 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_word_match_seq.md
Name: bank_word_match_seq

Overview:
- Parametrised, pipelined successor of the flattened single-output bank-compare cone.
- Holds NBANK stored words of WIDTH bits and selects one per compare through a one-hot select.
- Compares the selected word against a polarity-adjusted reference word.
- Registers the match result with a hold-when-disabled update, and keeps a saturating miss counter.
- Sits beside the control register file and feeds the status/next-state logic.

Parameters:
- WIDTH, 12, bits per stored word and reference word.
- NBANK, 3, number of stored banks; width of the one-hot select.
- CNT_W, 8, miss counter width.
- BW, $clog2(NBANK) (min 1), bank index width; derived, not overridable.

Ports:
- CK  in  1  clock, rising edge.
- RSTN  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  write strobe for the bank array.
- wr_bank  in  BW  bank index to write; values >= NBANK are ignored.
- wr_data  in  WIDTH  data to write.
- cmp_req  in  1  compare request, sampled each cycle.
- sel  in  NBANK  one-hot bank select, valid with cmp_req.
- ref_word  in  WIDTH  expected word, valid with cmp_req.
- ref_pol  in  WIDTH  per-bit polarity; 1 means compare against ~ref_word[i].
- upd_en  in  1  qualifier for updating the result register (clock-gate style enable).
- kill  in  1  blocks the update when 1.
- match  out  1  registered match result.
- match_vld  out  1  one-cycle pulse when match is updated.
- sel_err  out  1  one-cycle pulse: sel of the accepted request was not one-hot.
- miss_cnt  out  CNT_W  saturating count of accepted mismatches.

Behaviour:
- Reset (RSTN=0, async): all banks=0, pipeline valid=0, match=0, match_vld=0, sel_err=0, miss_cnt=0. Reset mid-operation drops any request in flight; no match_vld follows it.
- Write: on a CK edge with wr_en=1 and wr_bank<NBANK, bank[wr_bank]<=wr_data. Data is visible to compares sampled on the next cycle or later.
- Write/compare hazard: a compare sampled in the same cycle as a write to the selected bank uses the old contents.
- Stage S1 (cycle of cmp_req=1):
  - Capture sel_word = OR over i of (sel[i] ? bank[i] : 0).
  - Capture exp = ref_word ^ ref_pol.
  - Capture err = ~onehot(sel).
  - Capture acc = upd_en & ~kill.
  - s1_vld <= cmp_req.
- Stage S2 (next cycle, s1_vld=1):
  - eq = (sel_word == exp); the bitwise XNOR is AND-reduced.
  - If acc=1: match<=eq, match_vld<=1, sel_err<=err. If eq=0, miss_cnt<=miss_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - If acc=0: match holds its value, match_vld=0, sel_err=0, and the counter is unchanged (hold path, as in the old mux).
- Latency: cmp_req to match_vld is exactly 2 edges. Throughput is one compare per cycle; back-to-back requests pipeline.
- sel=0: sel_word=0, err=1; the compare still runs (match=1 only if exp==0).
- Multi-hot sel: sel_word is the OR of the selected banks, err=1, and the compare still runs.
- No handshake back-pressure; a request is never stalled.
- upd_en and kill are sampled with cmp_req, not at S2.

Optional Feature:
- Macro MATCH_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1 bit) and output miss_sticky (1 bit), reset 0.
  - miss_sticky is set on any accepted mismatch and cleared by sticky_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists and no sticky logic is present.

Test Plan:
- Reset, then write bank0=12'hA5C, bank1=12'h3F0, bank2=12'hFFF; cmp_req with sel=3'b010, ref=12'h3F0, pol=0, upd_en=1, kill=0 -> 2 cycles later match=1, match_vld=1, sel_err=0, miss_cnt=0.
- Same compare with ref=12'h3F1 -> match=0 and miss_cnt=1. Then with pol=12'h001 and ref=12'h3F1 -> match=1.
- Compare with kill=1 after a prior match=1, using a mismatching ref -> match stays 1, no match_vld, miss_cnt unchanged.
- Same-cycle write bank2<=12'h000 with a compare on sel=3'b100, ref=12'hFFF -> match=1 (old data). The following compare with ref=12'hFFF -> match=0.
- sel=3'b011, ref=12'hBFC -> sel_err pulse=1, match=1. sel=0, ref=0 -> sel_err=1, match=1.
- CNT_W=2 with 5 accepted mismatches -> miss_cnt saturates at 3. Assert RSTN low between the two pipeline stages -> match_vld is never seen and all outputs are 0.
